serial_cmp_seq: RTL and testbench

Sequential, bit-serial magnitude comparator with the same cascade semantics (eq/gt) as the parallel 8-bit comparator stage. It sits directly upstream of that stage in a cascaded chain. It captures two unsigned WIDTH-bit operands on a start strobe and resolves them MSB-first, one bit per clock. It then presents registered eq/gt results with a one-cycle done pulse, ready to drive the next stage's eq/gt cascade inputs.

---
 rtl/cmp_pkg.sv | 15 +
 rtl/cmp1_cell.sv | 16 +
 rtl/serial_cmp_seq.sv | 127 ++++++++++++
 tb/tb_serial_cmp_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and constants for the serial magnitude comparator.
// Holds the FSM state enum, the default operand width and the eq/gt reset values.
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cmp_state_t;

   localparam int   CMP_W_DEFAULT = 8;
   localparam logic CMP_EQ_RST    = 1'b1;
   localparam logic CMP_GT_RST    = 1'b0;

endpackage

// File: rtl/cmp1_cell.sv
// cmp1_cell: combinational one-bit eq/gt cascade cell, MSB-first resolution.
// Ports: ai, bi (operand bits), eq_i, gt_i (incoming flags), eq_o, gt_o (updated flags).
module cmp1_cell (
   input  logic ai,
   input  logic bi,
   input  logic eq_i,
   input  logic gt_i,
   output logic eq_o,
   output logic gt_o
);

   // Once the higher bits differ, the decision is frozen.
   assign eq_o = eq_i & ~(ai ^ bi);
   assign gt_o = eq_i ? (ai & ~bi) : gt_i;

endmodule

// File: rtl/serial_cmp_seq.sv
// serial_cmp_seq: bit-serial MSB-first unsigned comparator, one bit per clock.
// Ports: clk, rst (sync, active-high), start, a, b, eq_in, gt_in in;
//        busy, done (one-cycle pulse), eq, gt (registered results) out.
// Build option: define CMP_CASCADE_IN_EN to seed the working flags from eq_in/gt_in.
module serial_cmp_seq
   import cmp_pkg::*;
#(
   parameter int WIDTH = CMP_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             eq_in,
   input  logic             gt_in,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             gt
);

   localparam int CW = $clog2(WIDTH + 1);

   cmp_state_t       r_state;
   cmp_state_t       w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [CW-1:0]    r_cnt;
   logic             r_weq;
   logic             r_wgt;
   logic             r_eq;
   logic             r_gt;
   logic             w_load;
   logic             w_last;
   logic             w_eq_nxt;
   logic             w_gt_nxt;
   logic             w_seed_eq;
   logic             w_seed_gt;

`ifdef CMP_CASCADE_IN_EN
   assign w_seed_eq = eq_in;
   assign w_seed_gt = gt_in;
`else
   logic w_unused;
   assign w_unused  = ^{eq_in, gt_in};
   assign w_seed_eq = 1'b1;
   assign w_seed_gt = 1'b0;
`endif

   assign w_last = (r_cnt == CW'(WIDTH - 1));

   cmp1_cell u_cell (
      .ai   (r_a[WIDTH-1]),
      .bi   (r_b[WIDTH-1]),
      .eq_i (r_weq),
      .gt_i (r_wgt),
      .eq_o (w_eq_nxt),
      .gt_o (w_gt_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      w_load      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = RUN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_cnt <= '0;
         r_weq <= 1'b1;
         r_wgt <= 1'b0;
         r_eq  <= CMP_EQ_RST;
         r_gt  <= CMP_GT_RST;
      end else if (w_load) begin
         r_a   <= a;
         r_b   <= b;
         r_cnt <= '0;
         r_weq <= w_seed_eq;
         r_wgt <= w_seed_gt;
      end else if (r_state == RUN) begin
         r_a   <= {r_a[WIDTH-2:0], 1'b0};
         r_b   <= {r_b[WIDTH-2:0], 1'b0};
         r_cnt <= r_cnt + CW'(1);
         r_weq <= w_eq_nxt;
         r_wgt <= w_gt_nxt;
         if (w_last) begin
            r_eq <= w_eq_nxt;
            r_gt <= w_gt_nxt;
         end
      end
   end

   assign eq = r_eq;
   assign gt = r_gt;

endmodule

// File: tb/tb_serial_cmp_seq.sv
// tb_serial_cmp_seq: self-checking bench for serial_cmp_seq (WIDTH=8).
// Table-driven comparisons plus directed multi-cycle corner sequences.
module tb_serial_cmp_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       eq_in;
   logic       gt_in;
   logic       busy;
   logic       done;
   logic       eq;
   logic       gt;

   int checks   = 0;
   int failures = 0;
   logic prev_eq;
   logic prev_gt;

   serial_cmp_seq #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .eq_in (eq_in),
      .gt_in (gt_in),
      .busy  (busy),
      .done  (done),
      .eq    (eq),
      .gt    (gt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic       ei;
      logic       gi;
      logic       xeq;
      logic       xgt;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int n;
      string s;
      s = $sformatf("v%0d", idx);
      @(negedge clk);
      a     = v.va;
      b     = v.vb;
      eq_in = v.ei;
      gt_in = v.gi;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({s, "_busy"}, busy, 1'b1);
      n = 0;
      while (!done && n < 20) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 4) begin
            chk({s, "_hold_eq"}, eq, prev_eq);
            chk({s, "_hold_gt"}, gt, prev_gt);
         end
      end
      chk({s, "_lat"}, n, 8);
      chk({s, "_eq"}, eq, v.xeq);
      chk({s, "_gt"}, gt, v.xgt);
      chk({s, "_busy_done"}, busy, 1'b0);
      chk({s, "_inv"}, eq & gt, 1'b0);
      prev_eq = v.xeq;
      prev_gt = v.xgt;
      @(posedge clk);
      #1;
      chk({s, "_pulse"}, done, 1'b0);
   endtask

   initial begin
      int dcount;
      int busy_bad;
      int n;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      eq_in = 1'b1;
      gt_in = 1'b0;

      vecs[0] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'h3C, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{8'h7F, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{8'h5A, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef CMP_CASCADE_IN_EN
      vecs[6] = '{8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[8] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
`else
      vecs[6] = '{8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_eq", eq, 1'b1);
      chk("rst_gt", gt, 1'b0);
      prev_eq = 1'b1;
      prev_gt = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // second start while busy must be ignored
      @(negedge clk);
      eq_in    = 1'b1;
      gt_in    = 1'b0;
      a        = 8'h00;
      b        = 8'h01;
      start    = 1'b1;
      dcount   = 0;
      busy_bad = 0;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (busy !== 1'b1) busy_bad++;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (done) dcount++;
         if (i < 8 && busy !== 1'b1) busy_bad++;
         if (i == 2) begin
            a     = 8'hFF;
            b     = 8'h00;
            start = 1'b1;
         end
         if (i == 3) start = 1'b0;
         if (i == 8) begin
            chk("ign_done", done, 1'b1);
            chk("ign_eq", eq, 1'b0);
            chk("ign_gt", gt, 1'b0);
         end
      end
      chk("ign_busy", busy_bad, 0);
      chk("ign_npulse", dcount, 1);

      // reset in the middle of a run
      @(negedge clk);
      a     = 8'h01;
      b     = 8'h00;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_done", done, 1'b0);
      chk("mrst_eq", eq, 1'b1);
      chk("mrst_gt", gt, 1'b0);
      rst    = 1'b0;
      start  = 1'b0;
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) dcount++;
      end
      chk("mrst_quiet", dcount, 0);

      // back-to-back with start held through DONE
      @(negedge clk);
      a     = 8'h80;
      b     = 8'h7F;
      start = 1'b1;
      @(posedge clk);
      #1;
      n = 0;
      while (!done && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("b2b_lat1", n, 8);
      chk("b2b_eq1", eq, 1'b0);
      chk("b2b_gt1", gt, 1'b1);
      a = 8'h3C;
      b = 8'hC3;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!done && n < 20);
      start = 1'b0;
      chk("b2b_gap", n, 9);
      chk("b2b_eq2", eq, 1'b0);
      chk("b2b_gt2", gt, 1'b0);
      @(posedge clk);
      #1;
      chk("b2b_idle", busy, 1'b0);
      chk("b2b_nodone", done, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
